// File: rtl/vend_if.sv
// Vending controller bus: coin/selection/cancel strobes in, reject/dispense/change/credit out.
// The master modport is the machine front panel; the slave is the controller.
interface vend_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [2:0]          sel;
  logic                cancel;
  logic                coin_reject;
  logic                sel_reject;
  logic                dispense_valid;
  logic [2:0]          dispense_item;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel, change_ready,
    input  coin_reject, sel_reject, dispense_valid, dispense_item,
           change_valid, change_coin, credit, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel, change_ready,
    output coin_reject, sel_reject, dispense_valid, dispense_item,
           change_valid, change_coin, credit, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coin credit, dispenses priced items and
// pays change greedily one coin per handshake, with an idle-credit auto refund.
module vend_ctrl #(
  parameter int                             CREDIT_W   = 8,
  parameter int                             ITEM_CNT   = 6,
  parameter logic [ITEM_CNT*CREDIT_W-1:0]   PRICES     = {8'd15, 8'd25, 8'd50, 8'd75, 8'd85, 8'd100},
  parameter int                             MAX_CREDIT = 100,
  parameter int                             TIMEOUT    = 1000
) (
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);
  localparam int CW1 = CREDIT_W + 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [2:0]          item_q, item_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                coin_rej_q, coin_rej_d;
  logic                sel_rej_q, sel_rej_d;
  logic                live_q;

  logic [CW1-1:0] cred_w, sum_w, price_w, chg_w, rem_w;
  logic [1:0]     chg_coin;
  logic           coin_v, sel_v, cancel_v;

  function automatic logic [CW1-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return CW1'(5);
      2'd1:    return CW1'(10);
      2'd2:    return CW1'(25);
      default: return CW1'(100);
    endcase
  endfunction

  function automatic logic [CW1-1:0] price_of(input logic [2:0] idx);
    logic [CW1-1:0] p;
    p = '0;
    for (int i = 0; i < ITEM_CNT; i++)
      if (idx == 3'(i)) p = {1'b0, PRICES[i*CREDIT_W +: CREDIT_W]};
    return p;
  endfunction

  // Strobes are ignored on the first edge after reset release.
  assign coin_v   = bus.coin_valid & live_q;
  assign sel_v    = bus.sel_valid  & live_q;
  assign cancel_v = bus.cancel     & live_q;

  assign cred_w  = {1'b0, credit_q};
  assign sum_w   = cred_w + coin_value(bus.coin_type);
  assign price_w = price_of(bus.sel);

  always_comb begin
    chg_coin = 2'd0;
    if      (cred_w >= CW1'(100)) chg_coin = 2'd3;
    else if (cred_w >= CW1'(25))  chg_coin = 2'd2;
    else if (cred_w >= CW1'(10))  chg_coin = 2'd1;
  end

  assign chg_w = coin_value(chg_coin);
  assign rem_w = cred_w - chg_w;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_d     = item_q;
    cnt_d      = '0;
    coin_rej_d = 1'b0;
    sel_rej_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel_v) begin
          coin_rej_d = coin_v;
          if (credit_q != '0) state_d = CHANGE;
        end else if (sel_v) begin
          coin_rej_d = coin_v;
          if (int'(bus.sel) < ITEM_CNT && cred_w >= price_w) begin
            state_d  = DISPENSE;
            credit_d = CREDIT_W'(cred_w - price_w);
            item_d   = bus.sel;
          end else begin
            sel_rej_d = 1'b1;
          end
        end else if (coin_v) begin
          if (sum_w <= CW1'(MAX_CREDIT)) credit_d = sum_w[CREDIT_W-1:0];
          else                           coin_rej_d = 1'b1;
        end else if (TIMEOUT != 0 && credit_q != '0) begin
          if (cnt_q == TW'(TIMEOUT - 1)) state_d = CHANGE;
          else                           cnt_d   = cnt_q + TW'(1);
        end
      end
      DISPENSE: begin
        coin_rej_d = coin_v;
        state_d    = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_rej_d = coin_v;
        // Residue below the smallest coin is forfeited rather than paid.
        if (cred_w < CW1'(5)) begin
          credit_d = '0;
          state_d  = IDLE;
        end else if (bus.change_ready) begin
          if (rem_w < CW1'(5)) begin
            credit_d = '0;
            state_d  = IDLE;
          end else begin
            credit_d = rem_w[CREDIT_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item_q     <= '0;
      cnt_q      <= '0;
      coin_rej_q <= 1'b0;
      sel_rej_q  <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      cnt_q      <= cnt_d;
      coin_rej_q <= coin_rej_d;
      sel_rej_q  <= sel_rej_d;
      live_q     <= 1'b1;
    end
  end

  assign bus.coin_reject    = coin_rej_q;
  assign bus.sel_reject     = sel_rej_q;
  assign bus.dispense_valid = (state_q == DISPENSE);
  assign bus.dispense_item  = item_q;
  assign bus.change_valid   = (state_q == CHANGE) && (cred_w >= CW1'(5));
  assign bus.change_coin    = chg_coin;
  assign bus.credit         = credit_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus random coin/select/cancel traffic
// checked against a transaction-level credit/change model.
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_if #(.CREDIT_W(8)) vb ();
  vend_if #(.CREDIT_W(8)) tb2 ();

  vend_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(vb));
  vend_ctrl #(.TIMEOUT(4)) dut_t (.clk(clk), .rst_n(rst_n), .bus(tb2));

  int n_cmp = 0;
  int n_err = 0;
  int m_credit = 0;
  int prices[6] = '{100, 85, 75, 50, 25, 15};

  function automatic int coin_val(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pay out m_credit as greedy coins; optionally stall ready and inject busy-time coins.
  task automatic collect(input int stall_idx, input int stall_len, input bit rnd);
    int exp_q[$];
    int rem, stalled;
    bit rdy, cv, done;
    rem = m_credit;
    while (rem >= 5) begin
      if      (rem >= 100) exp_q.push_back(3);
      else if (rem >= 25)  exp_q.push_back(2);
      else if (rem >= 10)  exp_q.push_back(1);
      else                 exp_q.push_back(0);
      rem -= coin_val(exp_q[exp_q.size()-1]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      stalled = 0;
      done = 1'b0;
      for (int b = 0; b < 64 && !done; b++) begin
        chk("change_valid", 32'(vb.change_valid), 32'd1);
        chk("change_coin", 32'(vb.change_coin), 32'(exp_q[i]));
        if (i == stall_idx && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end else begin
          rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        cv = rnd && ($urandom_range(0, 4) == 0);
        vb.change_ready = rdy;
        vb.coin_valid   = cv;
        vb.coin_type    = 2'($urandom_range(0, 3));
        tick();
        vb.change_ready = 1'b0;
        vb.coin_valid   = 1'b0;
        chk("busy_coin_reject", 32'(vb.coin_reject), 32'(cv));
        if (rdy) begin
          m_credit -= coin_val(exp_q[i]);
          done = 1'b1;
        end
        chk("change_credit", 32'(vb.credit), 32'(m_credit));
      end
      if (!done) chk("change_timeout", 32'd0, 32'd1);
    end
    m_credit = 0;
    chk("after_change_busy", 32'(vb.busy), 32'd0);
    chk("after_change_valid", 32'(vb.change_valid), 32'd0);
  endtask

  task automatic do_coin(input int t);
    bit rej;
    rej = (m_credit + coin_val(t) > 100);
    vb.coin_valid = 1'b1;
    vb.coin_type  = 2'(t);
    tick();
    vb.coin_valid = 1'b0;
    if (!rej) m_credit += coin_val(t);
    chk("coin_reject", 32'(vb.coin_reject), 32'(rej));
    chk("coin_credit", 32'(vb.credit), 32'(m_credit));
  endtask

  task automatic do_sel(input int s, input bit rnd);
    bit ok;
    ok = (s < 6) && (m_credit >= prices[s < 6 ? s : 0]);
    vb.sel_valid = 1'b1;
    vb.sel       = 3'(s);
    tick();
    vb.sel_valid = 1'b0;
    chk("sel_reject", 32'(vb.sel_reject), 32'(!ok));
    if (ok) begin
      m_credit -= prices[s];
      chk("dispense_valid", 32'(vb.dispense_valid), 32'd1);
      chk("dispense_item", 32'(vb.dispense_item), 32'(s));
      chk("dispense_credit", 32'(vb.credit), 32'(m_credit));
      tick();
      chk("dispense_pulse_end", 32'(vb.dispense_valid), 32'd0);
      if (m_credit > 0) collect(-1, 0, rnd);
      else chk("dispense_idle", 32'(vb.busy), 32'd0);
    end else begin
      chk("sel_rej_credit", 32'(vb.credit), 32'(m_credit));
      chk("sel_rej_busy", 32'(vb.busy), 32'd0);
    end
  endtask

  task automatic do_cancel(input int stall_idx, input int stall_len, input bit rnd);
    vb.cancel = 1'b1;
    tick();
    vb.cancel = 1'b0;
    chk("cancel_busy", 32'(vb.busy), 32'(m_credit > 0));
    if (m_credit > 0) collect(stall_idx, stall_len, rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vb.coin_valid = 0; vb.coin_type = 0; vb.sel_valid = 0; vb.sel = 0;
    vb.cancel = 0; vb.change_ready = 0;
    tb2.coin_valid = 0; tb2.coin_type = 0; tb2.sel_valid = 0; tb2.sel = 0;
    tb2.cancel = 0; tb2.change_ready = 0;

    // Reset state, then a coin on the release edge must be ignored.
    repeat (3) tick();
    chk("rst_credit", 32'(vb.credit), 32'd0);
    chk("rst_busy", 32'(vb.busy), 32'd0);
    chk("rst_change_valid", 32'(vb.change_valid), 32'd0);
    chk("rst_dispense", 32'(vb.dispense_valid), 32'd0);
    chk("rst_coin_reject", 32'(vb.coin_reject), 32'd0);
    rst_n = 1'b1;
    vb.coin_valid = 1'b1; vb.coin_type = 2'd0;
    tick();
    vb.coin_valid = 1'b0;
    chk("release_credit", 32'(vb.credit), 32'd0);
    chk("release_reject", 32'(vb.coin_reject), 32'd0);

    // Nickel, dime, quarter; item 4 leaves 15 -> dime, nickel.
    do_coin(0); do_coin(1); do_coin(2);
    chk("credit_40", 32'(vb.credit), 32'd40);
    do_sel(4, 1'b0);

    // Dollar, rejected nickel, item 0 with no change.
    do_coin(3); do_coin(0);
    chk("credit_100", 32'(vb.credit), 32'd100);
    do_sel(0, 1'b0);

    // Credit 60 cancel with ready held low 3 cycles on the second coin.
    do_coin(2); do_coin(2); do_coin(1);
    chk("credit_60", 32'(vb.credit), 32'd60);
    do_cancel(1, 3, 1'b0);

    // Insufficient credit and out-of-range item.
    do_coin(2); do_coin(0);
    do_sel(2, 1'b0);
    chk("credit_30", 32'(vb.credit), 32'd30);
    do_sel(7, 1'b0);
    do_cancel(-1, 0, 1'b0);

    // Coincident strobes: selection beats coin, cancel beats coin.
    do_coin(2);
    vb.sel_valid = 1'b1; vb.sel = 3'd5; vb.coin_valid = 1'b1; vb.coin_type = 2'd1;
    tick();
    vb.sel_valid = 1'b0; vb.coin_valid = 1'b0;
    chk("prio_sel_reject", 32'(vb.sel_reject), 32'd0);
    chk("prio_coin_reject", 32'(vb.coin_reject), 32'd1);
    chk("prio_dispense_item", 32'(vb.dispense_item), 32'd5);
    chk("prio_credit", 32'(vb.credit), 32'd10);
    m_credit = 10;
    tick();
    collect(-1, 0, 1'b0);
    do_coin(1);
    vb.cancel = 1'b1; vb.coin_valid = 1'b1; vb.coin_type = 2'd0;
    tick();
    vb.cancel = 1'b0; vb.coin_valid = 1'b0;
    chk("cancel_coin_reject", 32'(vb.coin_reject), 32'd1);
    chk("cancel_busy_prio", 32'(vb.busy), 32'd1);
    chk("cancel_credit", 32'(vb.credit), 32'd10);
    collect(-1, 0, 1'b0);

    // Idle timeout of 4 cycles refunds a dime.
    tb2.coin_valid = 1'b1; tb2.coin_type = 2'd1;
    tick();
    tb2.coin_valid = 1'b0;
    chk("to_credit", 32'(tb2.credit), 32'd10);
    repeat (3) begin
      tick();
      chk("to_wait_busy", 32'(tb2.busy), 32'd0);
    end
    tick();
    chk("to_busy", 32'(tb2.busy), 32'd1);
    chk("to_change_valid", 32'(tb2.change_valid), 32'd1);
    chk("to_change_coin", 32'(tb2.change_coin), 32'd1);
    tb2.change_ready = 1'b1;
    tick();
    tb2.change_ready = 1'b0;
    chk("to_idle", 32'(tb2.busy), 32'd0);
    chk("to_credit_0", 32'(tb2.credit), 32'd0);

    // Reset in the middle of paying 35 back.
    do_coin(2); do_coin(1);
    vb.cancel = 1'b1;
    tick();
    vb.cancel = 1'b0;
    chk("mid_change_coin", 32'(vb.change_coin), 32'd2);
    chk("mid_credit", 32'(vb.credit), 32'd35);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_credit", 32'(vb.credit), 32'd0);
    chk("mid_rst_change_valid", 32'(vb.change_valid), 32'd0);
    chk("mid_rst_busy", 32'(vb.busy), 32'd0);
    m_credit = 0;
    tick();
    rst_n = 1'b1;
    vb.coin_valid = 1'b1; vb.coin_type = 2'd2;
    tick();
    vb.coin_valid = 1'b0;
    chk("mid_release_credit", 32'(vb.credit), 32'd0);

    // Random traffic against the credit/change model.
    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4)      do_coin($urandom_range(0, 3));
      else if (r <= 7) do_sel($urandom_range(0, 7), 1'b1);
      else             do_cancel(-1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
